// File: rtl/ai_paddle_driver.sv
// CPU opponent for the right-side Pong paddle. Drives the paddle block's active-low
// up/down buttons so the paddle follows the ball, with a reaction delay after the ball
// turns toward us, a deadband around the target and a press-rate limit.
// Optional feature: define AI_MISS_EN to add an LFSR-derived aim offset in TRACK.
module ai_paddle_driver #(
  parameter int unsigned DEADBAND    = 8,
  parameter int unsigned REACT_DELAY = 16,
  parameter int unsigned MOVE_DIV    = 4,
  parameter int unsigned HOME_Y      = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] ballYPos,
  input  logic       ballDirRight,
  input  logic [9:0] paddleCenterYPos,
  output logic       upButton,
  output logic       downButton
);

  localparam int unsigned RateW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned CntW  = (REACT_DELAY > 1) ? $clog2(REACT_DELAY) : 1;

  localparam logic [RateW-1:0]  RateMax   = (MOVE_DIV > 1) ? RateW'(MOVE_DIV - 1) : '0;
  localparam logic [CntW-1:0]   ReactLoad = (REACT_DELAY > 0) ? CntW'(REACT_DELAY - 1) : '0;
  localparam logic [9:0]        HomeY     = 10'(HOME_Y);
  localparam logic signed [10:0] DbPos    = 11'(DEADBAND);
  localparam logic signed [10:0] DbNeg    = -DbPos;

  typedef enum logic [1:0] {StIdle, StReact, StTrack} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   react_cnt_q, react_cnt_d;
  logic [RateW-1:0]  rate_q, rate_d;
  logic              dir_q, dir_d;
  logic              up_q, up_d;
  logic              down_q, down_d;
  logic [9:0]        track_y;
  logic [9:0]        target;
  logic signed [10:0] err;

  // Next-state: abort to IDLE on disable or receding ball, react on a rising direction edge.
  always_comb begin
    state_d     = state_q;
    react_cnt_d = react_cnt_q;
    dir_d       = ballDirRight;
    rate_d      = (rate_q == RateMax) ? '0 : rate_q + 1'b1;
    if (!enable || !ballDirRight) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!dir_q) begin
            if (REACT_DELAY == 0) begin
              state_d = StTrack;
            end else begin
              state_d     = StReact;
              react_cnt_d = ReactLoad;
            end
          end
        end
        StReact: begin
          if (react_cnt_q == '0) state_d = StTrack;
          else react_cnt_d = react_cnt_q - 1'b1;
        end
        StTrack: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef AI_MISS_EN
  logic [7:0]  lfsr_q, lfsr_d;
  logic [11:0] aim;

  // Step the LFSR on each departure from IDLE; aim at ball plus a signed -32..+31 offset.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StIdle && state_d != StIdle) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    // lfsr[5:0] - 32 is the 6-bit value with its msb inverted, read as signed.
    aim = {2'b00, ballYPos} + {{7{~lfsr_d[5]}}, lfsr_d[4:0]};
    if (aim[11])                track_y = '0;
    else if (aim > 12'd479)     track_y = 10'd479;
    else                        track_y = aim[9:0];
  end

  // LFSR state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign track_y = ballYPos;
`endif

  // Press decision for the state being entered; released in REACT and off the rate slot.
  always_comb begin
    target = (state_d == StTrack) ? track_y : HomeY;
    err    = $signed({1'b0, target}) - $signed({1'b0, paddleCenterYPos});
    up_d   = 1'b1;
    down_d = 1'b1;
    if (enable && state_d != StReact && rate_d == '0) begin
      if (err > DbPos)      up_d   = 1'b0;
      else if (err < DbNeg) down_d = 1'b0;
    end
  end

  // FSM, counters and registered button outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      react_cnt_q <= '0;
      rate_q      <= '0;
      dir_q       <= 1'b0;
      up_q        <= 1'b1;
      down_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      react_cnt_q <= react_cnt_d;
      rate_q      <= rate_d;
      dir_q       <= dir_d;
      up_q        <= up_d;
      down_q      <= down_d;
    end
  end

  assign upButton   = up_q;
  assign downButton = down_q;

endmodule

// File: tb/tb_ai_paddle_driver.sv
// Self-checking bench for ai_paddle_driver: directed scenarios plus randomized stimulus,
// each cycle compared against a behavioural model of the opponent.
module tb_ai_paddle_driver;

  localparam int DB   = 8;
  localparam int RD   = 16;
  localparam int MD   = 4;
  localparam int HOME = 240;

  localparam int MIdle  = 0;
  localparam int MReact = 1;
  localparam int MTrack = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] ballYPos;
  logic       ballDirRight;
  logic [9:0] paddleCenterYPos;
  logic       upButton;
  logic       downButton;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int         m_n;
  int         m_mode;
  int         m_left;
  int         m_prev;
  int         m_tgt;
  logic       exp_up;
  logic       exp_dn;
  logic [7:0] m_lfsr;

  ai_paddle_driver #(
    .DEADBAND   (DB),
    .REACT_DELAY(RD),
    .MOVE_DIV   (MD),
    .HOME_Y     (HOME)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .ballYPos        (ballYPos),
    .ballDirRight    (ballDirRight),
    .paddleCenterYPos(paddleCenterYPos),
    .upButton        (upButton),
    .downButton      (downButton)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n    = 0;
    m_mode = MIdle;
    m_left = 0;
    m_prev = 0;
    m_tgt  = HOME;
    m_lfsr = 8'hA5;
    exp_up = 1'b1;
    exp_dn = 1'b1;
  endtask

  // One clock edge of the opponent, using the inputs currently applied.
  task automatic model_edge();
    int err;
    int t;
    bit trig;
    trig = 0;
    m_n++;
    if (!enable || !ballDirRight) begin
      m_mode = MIdle;
    end else if (m_mode == MIdle) begin
      if (m_prev == 0) begin
        trig = 1;
        if (RD == 0) m_mode = MTrack;
        else begin
          m_mode = MReact;
          m_left = RD;
        end
      end
    end else if (m_mode == MReact) begin
      m_left--;
      if (m_left == 0) m_mode = MTrack;
    end
    m_prev = int'(ballDirRight);
    if (trig) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (m_mode == MTrack) begin
      t = int'(ballYPos);
`ifdef AI_MISS_EN
      t = t + int'(m_lfsr[5:0]) - 32;
      if (t < 0) t = 0;
      if (t > 479) t = 479;
`endif
    end else begin
      t = HOME;
    end
    m_tgt  = t;
    err    = t - int'(paddleCenterYPos);
    exp_up = 1'b1;
    exp_dn = 1'b1;
    if (enable && m_mode != MReact && (m_n % MD) == 0) begin
      if (err > DB)       exp_up = 1'b0;
      else if (err < -DB) exp_dn = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("buttons", int'({upButton, downButton}), int'({exp_up, exp_dn}));
    check("not_both_low", int'(upButton | downButton), 1);
  endtask

  task automatic run(input int n, output int ups, output int dns);
    ups = 0;
    dns = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (!upButton) ups++;
      if (!downButton) dns++;
    end
  endtask

  task automatic set_in(input int en, input int dir, input int ball, input int pad);
    enable           = en[0];
    ballDirRight     = dir[0];
    ballYPos         = 10'(ball);
    paddleCenterYPos = 10'(pad);
  endtask

  initial begin
    int ups, dns, k, cl, v, diff;
    reset = 1'b1;
    set_in(0, 0, 0, 240);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_btn", int'({upButton, downButton}), 3);
    reset = 1'b0;

    // Home seek: ball receding, paddle below home target
    set_in(1, 0, 0, 300);
    run(12, ups, dns);
    check("home_dn_cnt", dns, 3);
    check("home_up_cnt", ups, 0);
    paddleCenterYPos = 10'd245;
    run(8, ups, dns);
    check("home_db_cnt", ups + dns, 0);

    // Reaction delay
    set_in(1, 1, 400, 240);
    run(RD, ups, dns);
    check("react_quiet", ups + dns, 0);
    k = 0;
    while (upButton && k < MD) begin
      step();
      k++;
    end
    check("react_first_up", int'(upButton), 0);

    // Deadband edges in TRACK
    ballYPos = 10'd248;
    run(8, ups, dns);
    check("db_plus8", ups + dns, 0);
    ballYPos = 10'd249;
    run(8, ups, dns);
    check("db_plus9_up", ups, 2);
    ballYPos = 10'd231;
    run(8, ups, dns);
    check("db_minus9_dn", dns, 2);

    // Enable abort, then re-enable with direction held high: IDLE seeking home
    ballYPos = 10'd400;
    run(4, ups, dns);
    enable = 1'b0;
    step();
    check("abort_btn", int'({upButton, downButton}), 3);
    enable           = 1'b1;
    paddleCenterYPos = 10'd300;
    run(8, ups, dns);
    check("reen_home_dn", dns, 2);
    check("reen_home_up", ups, 0);

    // Asynchronous reset while pressing up in TRACK
    set_in(1, 0, 470, 100);
    step();
    ballDirRight = 1'b1;
    k = 0;
    while (upButton && k < 40) begin
      step();
      k++;
    end
    check("pre_rst_up", int'(upButton), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_btn", int'({upButton, downButton}), 3);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run(30, ups, dns);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ballDirRight = ~ballDirRight;
      if ($urandom_range(0, 39) == 0) enable = 1'b0;
      else if ($urandom_range(0, 3) == 0) enable = 1'b1;
      if ($urandom_range(0, 7) == 0) ballYPos = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 1023));
        else v = int'(ballYPos) + int'($urandom_range(0, 24)) - 12;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        paddleCenterYPos = 10'(v);
      end
      step();
    end

    // Closed loop with a simple paddle that moves one pixel per press
    cl = 240;
    set_in(1, 0, 100, cl);
    step();
    ballDirRight = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      paddleCenterYPos = 10'(cl);
      step();
      if (!upButton && downButton) cl++;
      else if (!downButton && upButton) cl--;
    end
    diff = cl - m_tgt;
    if (diff < 0) diff = -diff;
    check("closed_loop_conv", int'(diff <= DB), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
